alu_seq_arb: RTL and testbench
==============================

Name: alu_seq_arb

Overview:
- Shares one 16-bit datapath ALU between two requesters (e.g. execute-stage and address-gen ports).
- Round-robin arbitration, valid/ready request handshake, operand/opcode registering, result capture and a valid/ready response back to the winner.
- The ALU evaluates on the falling clock edge; this block sequences it so every result is captured one full cycle after issue.

Parameters:
- WIDTH, 16, operand/result width.
- START_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this edge when both valid and ready are high.
- req0_op  in  4  ALU control code.
- req0_a, req0_b  in  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- alu_ctrl  out  4  ALU control code.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_result  in  WIDTH  ALU output (updated on negedge).
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  1  requester the response belongs to.
- resp_result  out  WIDTH  captured result.
- resp_overflow  out  1  signed overflow (ADD/SUB only).
- resp_error  out  1  op was rejected.

Behaviour:
- Opcodes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100. All other codes are invalid.
- Reset (async, rst_n=0):
  - state IDLE; all ready and resp signals 0.
  - alu_ctrl=0000; alu_a and alu_b = 0.
  - priority pointer = START_PRIO.
  - An in-flight op is discarded and no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req*_ready is high only in IDLE, and only for the granted requester. Grant is combinational from valid and the pointer.
  - Only one valid requester: that requester is granted.
  - Both valid: the pointer's requester is granted.
  - On accept: register op/a/b onto alu_ctrl/alu_a/alu_b, record the id, set pointer = other requester, go to ISSUE.
  - Pointer is unchanged when nothing is accepted.
- ISSUE:
  - ALU computes on the intervening negedge.
  - At the next rising edge: capture alu_result into resp_result, compute resp_overflow, set resp_valid=1, go to RESP.
- RESP:
  - Hold all resp_* outputs stable while resp_valid=1 and resp_ready=0.
  - On a resp_valid & resp_ready edge: clear resp_valid and go to IDLE.
  - A new accept is possible on the next cycle. No accept happens in the same cycle as the response handshake.
- Latency: accept edge E0 → resp_valid high after E1. Minimum of 3 cycles per op.
- Overflow:
  - ADD: a[15]==b[15] && result[15]!=a[15].
  - SUB: a[15]!=b[15] && result[15]!=a[15].
  - All other ops: 0.
- alu_ctrl/alu_a/alu_b hold their last value outside ISSUE; they are not cleared.
- A requester's inputs are ignored unless it is accepted. A requester dropping valid before accept is legal.

Optional Feature:
- Macro: ALU_SEQ_ERRCHK_EN.
- Defined:
  - An invalid opcode is still accepted in IDLE, but is not driven to the ALU (alu_* keep their previous values).
  - The FSM goes directly IDLE→RESP with resp_error=1, resp_result=0, resp_overflow=0.
  - This gives 1-cycle latency to resp_valid.
- Undefined:
  - Every opcode is issued unchanged and resp_result is whatever the ALU produces.
  - resp_error is tied to 0.

Test Plan:
- Single requester: req0 ADD a=0x7FFF b=0x0001 → resp_id=0, resp_result=0x8000, resp_overflow=1, resp_valid rising 2 edges after accept.
- SUB and SLT: req1 SUB 0x0005−0x0007 → 0xFFFE, overflow=0. Then SLT 0x0003,0x0009 → 0x0001.
- Tie and fairness: both valid continuously with START_PRIO=0 → grants 0,1,0,1. The results match per-id ops (AND 0xF0F0&0xFF00=0xF000; NOR 0x00FF,0x0F00 → 0xF000).
- Backpressure: resp_ready low for 5 cycles → resp_* stable, both req*_ready=0. Raise resp_ready → one handshake, then IDLE.
- Reset mid-op: assert rst_n=0 in ISSUE → resp_valid=0 immediately, no response after release, pointer=START_PRIO.
- With ALU_SEQ_ERRCHK_EN: req0 op=0011 → resp_error=1, result=0 one edge after accept, alu_ctrl unchanged. Without the macro: resp_error stays 0.

Source files
------------

// File: rtl/alu_seq_arb_if.sv
// Bundles the two requester ports, the shared-ALU drive/return and the response port.
// No logic of its own, so it adds no latency.
// Backpressure travels on the req*_ready and resp_ready wires.
//
// Ports (slave = arbiter side, master = requesters, ALU and response consumer):
//   req0_* / req1_* : valid/ready op requests (op code, operands a/b)
//   alu_ctrl/alu_a/alu_b out to the ALU, alu_result back (ALU updates it on negedge)
//   resp_*          : valid/ready response (id, result, overflow, error)
interface alu_seq_arb_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_overflow;
    logic             resp_error;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_ctrl, alu_a, alu_b,
        input  alu_result,
        output resp_valid, resp_id, resp_result, resp_overflow, resp_error,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_ctrl, alu_a, alu_b,
        output alu_result,
        input  resp_valid, resp_id, resp_result, resp_overflow, resp_error,
        output resp_ready
    );
endinterface

// File: rtl/alu_seq_arb.sv
// Round-robin sharing of one negedge-evaluating ALU between two requesters.
// Accept edge E0 -> resp_valid after E1; at least 3 cycles per op.
// Backpressure: resp_ready low holds resp_* and keeps both req*_ready low.
//
// Ports: clk, rst_n (async active-low), bus (alu_seq_arb_if.slave) carrying the
// two request ports, the ALU drive/return and the response port.
// Optional macro ALU_SEQ_ERRCHK_EN: invalid opcodes are answered directly with
// resp_error=1 and never reach the ALU; without it resp_error stays 0.
module alu_seq_arb #(
    parameter int          WIDTH      = 16,
    parameter int unsigned START_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_arb_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic PRIO_RST = (START_PRIO != 0);

`ifdef ALU_SEQ_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic op_is_valid(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_is_valid = 1'b1;
            default:                                      op_is_valid = 1'b0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_overflow_q, resp_overflow_d;
    logic             resp_error_q, resp_error_d;

    logic             gnt0, gnt1;
    logic             acc0, acc1;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             issue_ok;
    logic             ovf_calc;

    // Grant is combinational: a lone valid wins, a tie goes to the pointer.
    always_comb begin
        gnt0   = bus.req0_valid && (!bus.req1_valid || (ptr_q == 1'b0));
        gnt1   = bus.req1_valid && (!bus.req0_valid || (ptr_q == 1'b1));
        acc0   = (state_q == IDLE) && gnt0;
        acc1   = (state_q == IDLE) && gnt1;
        sel_op = acc1 ? bus.req1_op : bus.req0_op;
        sel_a  = acc1 ? bus.req1_a  : bus.req0_a;
        sel_b  = acc1 ? bus.req1_b  : bus.req0_b;
        // Without error checking every opcode goes to the ALU unchanged.
        issue_ok = !ERRCHK || op_is_valid(sel_op);
    end

    // Signed overflow from the registered operands and the negedge ALU result.
    always_comb begin
        ovf_calc = 1'b0;
        case (alu_ctrl_q)
            OP_ADD: ovf_calc = (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1]) &&
                               (bus.alu_result[WIDTH-1] != alu_a_q[WIDTH-1]);
            OP_SUB: ovf_calc = (alu_a_q[WIDTH-1] != alu_b_q[WIDTH-1]) &&
                               (bus.alu_result[WIDTH-1] != alu_a_q[WIDTH-1]);
            default: ovf_calc = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        id_d            = id_q;
        alu_ctrl_d      = alu_ctrl_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        resp_valid_d    = resp_valid_q;
        resp_result_d   = resp_result_q;
        resp_overflow_d = resp_overflow_q;
        resp_error_d    = resp_error_q;

        case (state_q)
            IDLE: begin
                if (acc0 || acc1) begin
                    id_d  = acc1;
                    // Pointer moves to the requester that did not win.
                    ptr_d = acc0;
                    if (issue_ok) begin
                        alu_ctrl_d = sel_op;
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        state_d    = ISSUE;
                    end else begin
                        // Rejected op: ALU inputs untouched, answer straight away.
                        resp_valid_d    = 1'b1;
                        resp_result_d   = '0;
                        resp_overflow_d = 1'b0;
                        resp_error_d    = 1'b1;
                        state_d         = RESP;
                    end
                end
            end
            ISSUE: begin
                resp_valid_d    = 1'b1;
                resp_result_d   = bus.alu_result;
                resp_overflow_d = ovf_calc;
                resp_error_d    = 1'b0;
                state_d         = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ptr_q           <= PRIO_RST;
            id_q            <= 1'b0;
            alu_ctrl_q      <= 4'b0000;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            resp_valid_q    <= 1'b0;
            resp_result_q   <= '0;
            resp_overflow_q <= 1'b0;
            resp_error_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            id_q            <= id_d;
            alu_ctrl_q      <= alu_ctrl_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            resp_valid_q    <= resp_valid_d;
            resp_result_q   <= resp_result_d;
            resp_overflow_q <= resp_overflow_d;
            resp_error_q    <= resp_error_d;
        end
    end

    assign bus.req0_ready    = acc0;
    assign bus.req1_ready    = acc1;
    assign bus.alu_ctrl      = alu_ctrl_q;
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = id_q;
    assign bus.resp_result   = resp_result_q;
    assign bus.resp_overflow = resp_overflow_q;
    assign bus.resp_error    = resp_error_q;
endmodule

// File: tb/tb_alu_seq_arb.sv
// Directed bench for alu_seq_arb: vector table for single ops, then hand
// sequences for backpressure, reset mid-op, tie fairness and invalid opcodes.
// A behavioural ALU drives alu_result on the falling edge.
module tb_alu_seq_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_seq_arb_if #(.WIDTH(16)) bus();

    alu_seq_arb #(.WIDTH(16), .START_PRIO(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'b0000: alu_f = a & b;
            4'b0001: alu_f = a | b;
            4'b0010: alu_f = a + b;
            4'b0110: alu_f = a - b;
            4'b0111: alu_f = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
            4'b1100: alu_f = ~(a | b);
            default: alu_f = 16'hDEAD;
        endcase
    endfunction

    initial bus.alu_result = 16'h0000;
    always @(negedge clk) bus.alu_result <= alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic drive_req(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int  n;
        bit  got;
        @(posedge clk); #1;
        drive_req(v.id, v.op, v.a, v.b);
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if ((v.id ? bus.req1_ready : bus.req0_ready) === 1'b1) got = 1;
            else n++;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_accept: ready never seen within 20 cycles, expected 1", nm);
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check({nm, "_vld_e0"}, 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        check({nm, "_vld_e1"}, 32'(bus.resp_valid), 32'd1);
        check({nm, "_id"},     32'(bus.resp_id), 32'(v.id));
        check({nm, "_res"},    32'(bus.resp_result), 32'(v.res));
        check({nm, "_ovf"},    32'(bus.resp_overflow), 32'(v.ovf));
        check({nm, "_err"},    32'(bus.resp_error), 32'd0);
        @(posedge clk); #1;
        check({nm, "_vld_done"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        int  n;
        bit  got;

        vecs[0]  = '{1'b0, 4'b0010, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
        vecs[1]  = '{1'b1, 4'b0110, 16'h0005, 16'h0007, 16'hFFFE, 1'b0};
        vecs[2]  = '{1'b1, 4'b0111, 16'h0003, 16'h0009, 16'h0001, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
        vecs[4]  = '{1'b1, 4'b1100, 16'h00FF, 16'h0F00, 16'hF000, 1'b0};
        vecs[5]  = '{1'b0, 4'b0110, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
        vecs[6]  = '{1'b1, 4'b0010, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 4'b0111, 16'hFFFF, 16'h0001, 16'h0001, 1'b0};
        vecs[8]  = '{1'b1, 4'b0001, 16'h1200, 16'h0034, 16'h1234, 1'b0};
        vecs[9]  = '{1'b0, 4'b0010, 16'h1234, 16'h1111, 16'h2345, 1'b0};
        vecs[10] = '{1'b1, 4'b0110, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1};

        bus.req0_valid = 1'b0; bus.req0_op = 4'h0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
        bus.req1_valid = 1'b0; bus.req1_op = 4'h0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_alu_ctrl",   32'(bus.alu_ctrl), 32'd0);
        check("rst_alu_a",      32'(bus.alu_a), 32'd0);
        check("rst_alu_b",      32'(bus.alu_b), 32'd0);
        check("rst_error",      32'(bus.resp_error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);

        // Single ops from the vector table
        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: hold response for 5 cycles with a competing request pending
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        drive_req(1'b0, 4'b0010, 16'h1234, 16'h1111);
        @(negedge clk);
        check("bp_accept", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        drive_req(1'b1, 4'b0000, 16'hFFFF, 16'h00FF);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_vld", k), 32'(bus.resp_valid), 32'd1);
            check($sformatf("bp_hold%0d_res", k), {15'd0, bus.resp_id, bus.resp_result}, 32'h0000_2345);
            check($sformatf("bp_hold%0d_rdy", k), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_vld", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check("bp_idle_rdy1", 32'(bus.req1_ready), 32'd1);
        bus.req1_valid = 1'b0;

        // Reset while an op is in ISSUE
        @(posedge clk); #1;
        drive_req(1'b0, 4'b0010, 16'h0001, 16'h0002);
        @(negedge clk);
        check("mrst_accept", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_vld_now", 32'(bus.resp_valid), 32'd0);
        check("mrst_ctrl",    32'(bus.alu_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mrst_no_resp%0d", k), 32'(bus.resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        drive_req(1'b0, 4'b0000, 16'hF0F0, 16'hFF00);
        drive_req(1'b1, 4'b1100, 16'h00FF, 16'h0F00);
        @(negedge clk);
        check("mrst_ptr", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);

        // Tie fairness: both stay valid, grants must alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            n = 0; got = 0;
            while (!got && n < 20) begin
                if (bus.resp_valid === 1'b1) got = 1;
                else begin @(negedge clk); n++; end
            end
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL rr%0d_resp: no response within 20 cycles, expected one", k);
            end else begin
                check($sformatf("rr%0d_id", k),  32'(bus.resp_id), 32'(k % 2));
                check($sformatf("rr%0d_res", k), 32'(bus.resp_result), 32'h0000_F000);
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Invalid opcode after a known issued op
        run_vec('{1'b0, 4'b0001, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0}, "pre_inv");
        @(posedge clk); #1;
        drive_req(1'b0, 4'b0011, 16'h0005, 16'h0006);
        @(negedge clk);
        check("inv_accept", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
`ifdef ALU_SEQ_ERRCHK_EN
        check("inv_vld_e0", 32'(bus.resp_valid), 32'd1);
        check("inv_err",    32'(bus.resp_error), 32'd1);
        check("inv_res",    32'(bus.resp_result), 32'd0);
        check("inv_ovf",    32'(bus.resp_overflow), 32'd0);
        check("inv_ctrl",   32'(bus.alu_ctrl), 32'h1);
        check("inv_a",      32'(bus.alu_a), 32'h00F0);
        @(posedge clk); #1;
        check("inv_done",   32'(bus.resp_valid), 32'd0);
`else
        check("inv_vld_e0", 32'(bus.resp_valid), 32'd0);
        check("inv_ctrl",   32'(bus.alu_ctrl), 32'h3);
        @(posedge clk); #1;
        check("inv_vld_e1", 32'(bus.resp_valid), 32'd1);
        check("inv_err",    32'(bus.resp_error), 32'd0);
        check("inv_res",    32'(bus.resp_result), 32'hDEAD);
        @(posedge clk); #1;
        check("inv_done",   32'(bus.resp_valid), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
